// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: key event record,
// prefix decoder states and the two prefix scan codes.
package ps2_pkg;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   typedef enum logic [1:0] {
      D_IDLE,
      D_EXT,
      D_BRK,
      D_EXTBRK
   } dec_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Odd parity over eight data bits plus the parity bit.
   function automatic logic ps2_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic show-ahead FIFO: o_data always shows the head entry; a push while full
// is accepted only when a pop happens in the same cycle.
module ps2_evt_fifo #(
   parameter int  DEPTH = 8,
   parameter type T     = logic [7:0]
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  T                       i_data,
   output logic                   o_full,
   input  logic                   i_pop,
   output T                       o_data,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   T              r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;

   logic w_do_pop;
   logic w_do_push;

   assign o_full    = (r_level == LVL_FULL);
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // When full, wr_ptr == rd_ptr: a push+pop overwrites the slot being vacated.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_evt.sv
// PS/2 device-to-host receiver: sync, deframe, E0/F0 decode into key events, event FIFO.
// Optional macro PS2_RX_TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module ps2_rx_evt
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ps2_clk,
   input  logic                        ps2_data,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [9:0]                  evt_data,
   output logic [$clog2(FIFO_DEPTH):0] evt_level,
   output logic [7:0]                  press_cnt,
   output logic                        frame_err,
   output logic                        ovf,
   input  logic                        ovf_clr,
   output dec_state_t                  o_dbg_state
);

   localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1);
   localparam logic [3:0]    CNT_STOP = 4'd10;

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic [9:0]             r_bits;
   logic [3:0]             r_cnt;
   logic [TW-1:0]          r_to_cnt;
   logic                   r_byte_vld;
   logic [7:0]             r_byte;
   logic                   r_frame_err;
   dec_state_t             r_state;
   logic [7:0]             r_press_cnt;
   logic                   r_ovf;

   logic       w_clk_s;
   logic       w_dat_s;
   logic       w_strobe;
   logic       w_frame_ok;
   dec_state_t w_state_nxt;
   logic       w_emit;
   ps2_evt_t   w_evt;
   logic       w_push;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic       w_accept;
   ps2_evt_t   w_head;

   assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
   assign w_dat_s  = r_dat_sync[SYNC_STAGES-1];
   assign w_strobe = r_clk_prev && !w_clk_s;
   // Evaluated on the stop-bit strobe, so the stop bit is the live synced data.
   assign w_frame_ok = !r_bits[0] && w_dat_s && ps2_parity_ok(r_bits[9:1]);

   // Sync flops reset low so only a genuine 1->0 on the pin can make a strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync <= '0;
         r_dat_sync <= '0;
         r_clk_prev <= 1'b0;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_prev <= w_clk_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bits      <= '0;
         r_cnt       <= '0;
         r_to_cnt    <= '0;
         r_byte_vld  <= 1'b0;
         r_byte      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_strobe) begin
            r_to_cnt <= '0;
            if (r_cnt == CNT_STOP) begin
               r_cnt       <= '0;
               r_byte_vld  <= w_frame_ok;
               r_frame_err <= !w_frame_ok;
               r_byte      <= r_bits[8:1];
            end else begin
               r_bits[r_cnt] <= w_dat_s;
               r_cnt         <= r_cnt + 4'd1;
            end
         end else if (r_cnt == '0) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt == TO_LAST) begin
            r_cnt       <= '0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b1;
         end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= D_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_evt       = '0;
      if (r_byte_vld) begin
         case (r_state)
            D_IDLE: begin
               if (r_byte == PS2_EXT) begin
                  w_state_nxt = D_EXT;
               end else if (r_byte == PS2_BRK) begin
                  w_state_nxt = D_BRK;
               end else begin
                  w_emit = 1'b1;
                  w_evt  = '{ext: 1'b0, brk: 1'b0, code: r_byte};
               end
            end
            D_EXT: begin
               if (r_byte == PS2_BRK) begin
                  w_state_nxt = D_EXTBRK;
               end else if (r_byte != PS2_EXT) begin
                  w_emit      = 1'b1;
                  w_evt       = '{ext: 1'b1, brk: 1'b0, code: r_byte};
                  w_state_nxt = D_IDLE;
               end
            end
            D_BRK: begin
               if (r_byte != PS2_EXT && r_byte != PS2_BRK) begin
                  w_emit      = 1'b1;
                  w_evt       = '{ext: 1'b0, brk: 1'b1, code: r_byte};
                  w_state_nxt = D_IDLE;
               end
            end
            default: begin
               if (r_byte != PS2_EXT && r_byte != PS2_BRK) begin
                  w_emit      = 1'b1;
                  w_evt       = '{ext: 1'b1, brk: 1'b1, code: r_byte};
                  w_state_nxt = D_IDLE;
               end
            end
         endcase
      end
   end

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
   logic       r_last_vld;
   logic [8:0] r_last;
   logic       w_same;

   assign w_same = r_last_vld && (r_last == {w_evt.ext, w_evt.code});
   assign w_push = w_emit && (w_evt.brk || !w_same);

   // Tracks the held key regardless of whether its event reached the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_vld <= 1'b0;
         r_last     <= '0;
      end else if (w_emit) begin
         if (w_evt.brk) begin
            if (w_same) begin
               r_last_vld <= 1'b0;
            end
         end else if (!w_same) begin
            r_last_vld <= 1'b1;
            r_last     <= {w_evt.ext, w_evt.code};
         end
      end
   end
`else
   assign w_push = w_emit;
`endif

   assign w_pop    = evt_ready && !w_empty;
   assign w_accept = w_push && (!w_full || w_pop);

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (ps2_evt_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_evt),
      .o_full  (w_full),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_level (evt_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_press_cnt <= '0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_accept && !w_evt.brk) begin
            r_press_cnt <= r_press_cnt + 8'd1;
         end
         if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign evt_valid   = !w_empty;
   assign evt_data    = evt_valid ? w_head : '0;
   assign press_cnt   = r_press_cnt;
   assign frame_err   = r_frame_err;
   assign ovf         = r_ovf;
   assign o_dbg_state = r_state;

endmodule
